mc_ctrl: RTL and testbench

Multi-cycle control unit that sequences the shared MIPS datapath (PC, IR, register file, ALU, memory/IO port) one micro-step per clock.
- Decodes opcode/funct.
- Stalls on the memory/IO ready handshake (MIO_ready).
- Takes external interrupts at instruction boundaries and returns from them with eret.
- Replaces the single-cycle control path. Its outputs drive the datapath muxes, register write enables and the memory bus request.

---
 rtl/mc_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: walks the shared datapath one micro-step per clock,
// stalls on MIO_ready and takes interrupts only at instruction boundaries.
module mc_ctrl #(
  parameter logic INT_EN_DEFAULT = 1'b1,
  parameter bit   IF_WAIT        = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       MIO_ready,
  input  logic       INT,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       Branch_ne,
  output logic       IorD,
  output logic       MemRead,
  output logic       mem_w,
  output logic       CPU_MIO,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_Control,
  output logic [2:0] PCSource,
  output logic       EPCWrite,
  output logic       int_ack,
  output logic [3:0] state_out
);
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MA = 4'd2, S_MR = 4'd3,
    S_LWB = 4'd4, S_MW = 4'd5, S_REX = 4'd6, S_RWB = 4'd7,
    S_BR = 4'd8, S_J = 4'd9, S_IEX = 4'd10, S_IWB = 4'd11,
    S_JAL = 4'd12, S_JR = 4'd13, S_INTE = 4'd14, S_ERET = 4'd15
  } state_t;

  localparam logic [2:0] ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_ADD = 3'd2, ALU_XOR = 3'd3,
                         ALU_NOR = 3'd4, ALU_SRL = 3'd5, ALU_SUB = 3'd6, ALU_SLT = 3'd7;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c,
                         OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_COP0 = 6'h10,
                         OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_JR = 6'h08, F_ERET = 6'h18;

  state_t state;
  logic   int_en;
  logic   fetch_done;
  state_t fin;

  // The zero flag is consumed by the datapath's branch gate, not by sequencing.
  logic unused_zero;
  assign unused_zero = zero;

  assign fetch_done = MIO_ready || !IF_WAIT;
  assign fin        = (INT && int_en) ? S_INTE : S_IF;

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h26:   r_alu = ALU_XOR;
      6'h27:   r_alu = ALU_NOR;
      6'h2a:   r_alu = ALU_SLT;
      6'h02:   r_alu = ALU_SRL;
      default: r_alu = ALU_ADD;
    endcase
  endfunction

  function automatic logic r_known(input logic [5:0] f);
    r_known = f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02};
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: i_alu = ALU_AND;
      OP_ORI:  i_alu = ALU_OR;
      OP_XORI: i_alu = ALU_XOR;
      OP_SLTI: i_alu = ALU_SLT;
      default: i_alu = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IF;
      int_en <= INT_EN_DEFAULT;
    end else begin
      case (state)
        S_IF:  if (fetch_done) state <= S_ID;
        S_ID: begin
          case (opcode)
            OP_R:                                    state <= (funct == F_JR) ? S_JR : S_REX;
            OP_LW, OP_SW:                            state <= S_MA;
            OP_BEQ, OP_BNE:                          state <= S_BR;
            OP_J:                                    state <= S_J;
            OP_JAL:                                  state <= S_JAL;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state <= S_IEX;
            OP_LUI:                                  state <= S_IWB;
            OP_COP0:                                 state <= (funct == F_ERET) ? S_ERET : fin;
            default:                                 state <= fin;
          endcase
        end
        S_MA:  state <= opcode[3] ? S_MW : S_MR;
        S_MR:  if (MIO_ready) state <= S_LWB;
        S_MW:  if (MIO_ready) state <= fin;
        S_REX: state <= S_RWB;
        S_IEX: state <= S_IWB;
        S_LWB, S_RWB, S_IWB, S_BR, S_J, S_JAL, S_JR: state <= fin;
        S_INTE: begin
          int_en <= 1'b0;
          state  <= S_IF;
        end
        // No boundary check here so the instruction after eret always retires.
        S_ERET: begin
          int_en <= 1'b1;
          state  <= S_IF;
        end
      endcase
    end
  end

  // Outputs decode the state register; holding reset forces every strobe low.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch_ne   = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    mem_w       = 1'b0;
    CPU_MIO     = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_Control = ALU_AND;
    PCSource    = 3'b000;
    EPCWrite    = 1'b0;
    int_ack     = 1'b0;
    state_out   = 4'd0;
    if (reset) begin
      state_out = state;
      case (state)
        S_IF: begin
          MemRead     = 1'b1;
          CPU_MIO     = 1'b1;
          ALUSrcB     = 2'b01;
          ALU_Control = ALU_ADD;
          IRWrite     = fetch_done;
          PCWrite     = fetch_done;
        end
        S_ID: begin
          ALUSrcB     = 2'b11;
          ALU_Control = ALU_ADD;
        end
        S_MA: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = 2'b10;
          ALU_Control = ALU_ADD;
        end
        S_MR: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          CPU_MIO = 1'b1;
        end
        S_LWB: begin
          MemtoReg = 2'b01;
          RegWrite = 1'b1;
        end
        S_MW: begin
          IorD    = 1'b1;
          mem_w   = 1'b1;
          CPU_MIO = 1'b1;
        end
        S_REX: begin
          ALUSrcA     = 1'b1;
          ALU_Control = r_alu(funct);
        end
        S_RWB: begin
          RegDst   = 2'b01;
          RegWrite = r_known(funct);
        end
        S_IEX: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = 2'b10;
          ALU_Control = i_alu(opcode);
        end
        S_IWB: begin
          RegWrite = 1'b1;
          MemtoReg = (opcode == OP_LUI) ? 2'b11 : 2'b00;
        end
        S_BR: begin
          ALUSrcA     = 1'b1;
          ALU_Control = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 3'b001;
          Branch_ne   = opcode[0];
        end
        S_J: begin
          PCWrite  = 1'b1;
          PCSource = 3'b010;
        end
        S_JAL: begin
          PCWrite  = 1'b1;
          PCSource = 3'b010;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
          RegWrite = 1'b1;
        end
        S_JR: begin
          PCWrite  = 1'b1;
          PCSource = 3'b011;
        end
        S_INTE: begin
          EPCWrite = 1'b1;
          PCWrite  = 1'b1;
          PCSource = 3'b101;
          int_ack  = 1'b1;
        end
        S_ERET: begin
          PCWrite  = 1'b1;
          PCSource = 3'b100;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level model expands each instruction into its
// expected micro-step trace; a negedge process compares every cycle against it.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] ir;
  logic zero, MIO_ready, INT;
  logic PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, mem_w, CPU_MIO, IRWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB;
  logic RegWrite, ALUSrcA, EPCWrite, int_ack;
  logic [2:0] ALU_Control, PCSource;
  logic [3:0] state_out;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(ir[31:26]), .funct(ir[5:0]), .zero(zero),
    .MIO_ready(MIO_ready), .INT(INT), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Branch_ne(Branch_ne), .IorD(IorD), .MemRead(MemRead), .mem_w(mem_w),
    .CPU_MIO(CPU_MIO), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control),
    .PCSource(PCSource), .EPCWrite(EPCWrite), .int_ack(int_ack), .state_out(state_out)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, bne, iord, mrd, mw, mio, irw;
    logic [1:0] rdst, m2r;
    logic rw, asa;
    logic [1:0] asb;
    logic [2:0] alu, pcs;
    logic epcw, ack;
  } exp_t;

  typedef struct {
    logic [31:0] got;
    logic [31:0] want;
    string nm;
  } pin_t;

  exp_t act;
  assign act = {state_out, PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, mem_w, CPU_MIO,
                IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALU_Control, PCSource,
                EPCWrite, int_ack};

  localparam logic [2:0] A_AND = 3'd0, A_OR = 3'd1, A_ADD = 3'd2, A_XOR = 3'd3,
                         A_NOR = 3'd4, A_SRL = 3'd5, A_SUB = 3'd6, A_SLT = 3'd7;
  localparam int C_R = 0, C_JR = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_J = 5, C_JAL = 6,
                 C_IALU = 7, C_LUI = 8, C_ERET = 9, C_NOP = 10;

  exp_t exp_q[$];
  pin_t pin_q[$];
  exp_t trace[$];
  int   n_cyc;
  logic m_int_en;
  int   checks = 0;
  int   failures = 0;

  always @(negedge clk) begin
    exp_t e;
    pin_t p;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL cycle t=%0t state got=%0d want=%0d outputs got=%07h want=%07h",
                 $time, act.st, e.st, act, e);
      end
    end
    while (pin_q.size() != 0) begin
      p = pin_q.pop_front();
      checks++;
      if (p.got !== p.want) begin
        failures++;
        $display("FAIL %s got=%0h want=%0h", p.nm, p.got, p.want);
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h08) ? C_JR : C_R;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h04, 6'h05: return C_BR;
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a: return C_IALU;
      6'h0f: return C_LUI;
      6'h10: return (fn == 6'h18) ? C_ERET : C_NOP;
      default: return C_NOP;
    endcase
  endfunction

  function automatic logic [2:0] r_op(input logic [5:0] fn);
    case (fn)
      6'h22: return A_SUB;
      6'h24: return A_AND;
      6'h25: return A_OR;
      6'h26: return A_XOR;
      6'h27: return A_NOR;
      6'h2a: return A_SLT;
      6'h02: return A_SRL;
      default: return A_ADD;
    endcase
  endfunction

  function automatic logic i_op(input logic [5:0] op, output logic [2:0] a);
    a = (op == 6'h0c) ? A_AND : (op == 6'h0d) ? A_OR : (op == 6'h0e) ? A_XOR :
        (op == 6'h0a) ? A_SLT : A_ADD;
    return 1'b1;
  endfunction

  function automatic logic lvl(input int im, input int n);
    return (im == 1) || (im == 2 && n == 0);
  endfunction

  task automatic tick(input exp_t e, input logic mio, input logic iv);
    MIO_ready = mio;
    INT = iv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic st(input exp_t e, input logic mio, input int im);
    trace.push_back(e);
    tick(e, mio, lvl(im, n_cyc));
    n_cyc++;
  endtask

  task automatic pin_e(input string nm, input exp_t g, input exp_t w);
    pin_t p;
    p.got = {4'b0, g}; p.want = {4'b0, w}; p.nm = nm;
    pin_q.push_back(p);
  endtask

  task automatic pin_i(input string nm, input int g, input int w);
    pin_t p;
    p.got = 32'(g); p.want = 32'(w); p.nm = nm;
    pin_q.push_back(p);
  endtask

  // ifw: fetch wait cycles, mwt: memory wait cycles, im: 0 no INT, 1 INT held, 2 INT only in first cycle
  task automatic run(input logic [31:0] instr, input int ifw, input int mwt, input int im);
    logic [5:0] op, fn;
    exp_t e;
    int k;
    logic dummy;
    op = instr[31:26];
    fn = instr[5:0];
    k = cls(op, fn);
    ir = instr;
    trace.delete();
    n_cyc = 0;
    for (int i = 0; i <= ifw; i++) begin
      e = mk(4'd0); e.mrd = 1; e.mio = 1; e.asb = 2'b01; e.alu = A_ADD;
      if (i == ifw) begin e.irw = 1; e.pcw = 1; end
      st(e, i == ifw, im);
    end
    e = mk(4'd1); e.asb = 2'b11; e.alu = A_ADD; st(e, 1'b1, im);
    case (k)
      C_R: begin
        e = mk(4'd6); e.asa = 1; e.alu = r_op(fn); st(e, 1'b1, im);
        e = mk(4'd7); e.rdst = 2'b01;
        e.rw = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02};
        st(e, 1'b1, im);
      end
      C_JR: begin e = mk(4'd13); e.pcw = 1; e.pcs = 3'd3; st(e, 1'b1, im); end
      C_LW, C_SW: begin
        e = mk(4'd2); e.asa = 1; e.asb = 2'b10; e.alu = A_ADD; st(e, 1'b1, im);
        for (int i = 0; i <= mwt; i++) begin
          e = mk((k == C_LW) ? 4'd3 : 4'd5); e.iord = 1; e.mio = 1;
          if (k == C_LW) e.mrd = 1; else e.mw = 1;
          st(e, i == mwt, im);
        end
        if (k == C_LW) begin e = mk(4'd4); e.m2r = 2'b01; e.rw = 1; st(e, 1'b1, im); end
      end
      C_BR: begin
        e = mk(4'd8); e.asa = 1; e.alu = A_SUB; e.pcwc = 1; e.pcs = 3'd1; e.bne = op[0];
        st(e, 1'b1, im);
      end
      C_J:   begin e = mk(4'd9); e.pcw = 1; e.pcs = 3'd2; st(e, 1'b1, im); end
      C_JAL: begin
        e = mk(4'd12); e.pcw = 1; e.pcs = 3'd2; e.rdst = 2'b10; e.m2r = 2'b10; e.rw = 1;
        st(e, 1'b1, im);
      end
      C_IALU: begin
        e = mk(4'd10); e.asa = 1; e.asb = 2'b10; dummy = i_op(op, e.alu); st(e, 1'b1, im);
        e = mk(4'd11); e.rw = 1; st(e, 1'b1, im);
      end
      C_LUI:  begin e = mk(4'd11); e.rw = 1; e.m2r = 2'b11; st(e, 1'b1, im); end
      C_ERET: begin e = mk(4'd15); e.pcw = 1; e.pcs = 3'd4; st(e, 1'b1, im); end
      default: ;
    endcase
    if (k == C_ERET) m_int_en = 1'b1;
    else if (lvl(im, n_cyc - 1) && m_int_en) begin
      e = mk(4'd14); e.epcw = 1; e.pcw = 1; e.pcs = 3'd5; e.ack = 1;
      trace.push_back(e);
      tick(e, 1'b1, lvl(im, n_cyc));
      m_int_en = 1'b0;
    end
  endtask

  logic [31:0] rtab[5] = '{32'h00221824, 32'h00221825, 32'h00221826, 32'h0022182A, 32'h00010842};
  logic [31:0] otab[6] = '{32'h30220003, 32'h38220003, 32'h28220003, 32'h08000010,
                           32'h0C000010, 32'h03E00008};

  initial begin
    exp_t e;
    reset = 1'b0; ir = '0; zero = 1'b0; MIO_ready = 1'b1; INT = 1'b0; m_int_en = 1'b1;
    @(posedge clk); #1;
    tick(mk(4'd0), 1'b1, 1'b0);
    tick(mk(4'd0), 1'b1, 1'b0);
    reset = 1'b1;

    run(32'h00000827, 0, 0, 0);
    pin_i("nor_cycles", n_cyc, 4);
    pin_e("nor_rex", trace[2], '{st: 4'd6, asa: 1'b1, alu: 3'd4, default: '0});
    pin_e("nor_rwb", trace[3], '{st: 4'd7, rdst: 2'b01, rw: 1'b1, default: '0});

    run(32'h8C220004, 0, 2, 0);
    pin_i("lw_wait_cycles", n_cyc, 7);
    pin_e("lw_mr", trace[4], '{st: 4'd3, iord: 1'b1, mrd: 1'b1, mio: 1'b1, default: '0});
    pin_e("lw_lwb", trace[6], '{st: 4'd4, m2r: 2'b01, rw: 1'b1, default: '0});

    run(32'hAC220008, 3, 0, 0);
    pin_i("sw_ifwait_cycles", n_cyc, 7);
    pin_e("sw_if_stall", trace[1], '{st: 4'd0, mrd: 1'b1, mio: 1'b1, asb: 2'b01, alu: 3'd2, default: '0});
    pin_e("sw_mw", trace[6], '{st: 4'd5, iord: 1'b1, mw: 1'b1, mio: 1'b1, default: '0});

    run(32'h14220003, 0, 0, 0);
    pin_i("bne_cycles", n_cyc, 3);
    pin_e("bne_br", trace[2], '{st: 4'd8, asa: 1'b1, alu: 3'd6, pcwc: 1'b1, pcs: 3'd1, bne: 1'b1, default: '0});
    run(32'h10220003, 0, 0, 0);
    pin_e("beq_br", trace[2], '{st: 4'd8, asa: 1'b1, alu: 3'd6, pcwc: 1'b1, pcs: 3'd1, default: '0});

    // Interrupt entry, masked second request, eret, then one instruction before re-entry.
    run(32'h00221820, 0, 0, 1);
    pin_i("int_trace_len", trace.size(), 5);
    pin_e("int_inte", trace[4], '{st: 4'd14, epcw: 1'b1, pcw: 1'b1, pcs: 3'd5, ack: 1'b1, default: '0});
    run(32'h20220005, 0, 0, 1);
    pin_i("int_masked_len", trace.size(), 4);
    run(32'h42000018, 0, 0, 1);
    pin_i("eret_len", trace.size(), 3);
    run(32'h34220001, 0, 0, 1);
    pin_i("int_after_eret_len", trace.size(), 5);
    run(32'h42000018, 0, 0, 0);
    run(32'h00221822, 0, 0, 2);
    pin_i("int_early_drop_len", trace.size(), 4);

    run(32'h00000001, 0, 0, 0);
    pin_e("rwb_unknown_funct", trace[3], '{st: 4'd7, rdst: 2'b01, default: '0});
    for (int i = 0; i < 5; i++) run(rtab[i], 0, 0, 0);
    for (int i = 0; i < 6; i++) run(otab[i], 1, 0, 0);
    run(32'h3C010001, 0, 0, 0);
    pin_i("lui_cycles", n_cyc, 3);
    pin_e("lui_iwb", trace[2], '{st: 4'd11, m2r: 2'b11, rw: 1'b1, default: '0});

    run(32'hFC000000, 0, 0, 1);
    pin_i("nop_int_len", trace.size(), 3);
    run(32'h42000018, 0, 0, 0);

    // Abort a stalled store with an asynchronous reset between edges.
    ir = 32'hAC220008;
    e = mk(4'd0); e.mrd = 1; e.mio = 1; e.asb = 2'b01; e.alu = A_ADD; e.irw = 1; e.pcw = 1;
    tick(e, 1'b1, 1'b0);
    e = mk(4'd1); e.asb = 2'b11; e.alu = A_ADD; tick(e, 1'b1, 1'b0);
    e = mk(4'd2); e.asa = 1; e.asb = 2'b10; e.alu = A_ADD; tick(e, 1'b1, 1'b0);
    e = mk(4'd5); e.iord = 1; e.mw = 1; e.mio = 1; tick(e, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    exp_q.push_back(mk(4'd0));
    @(posedge clk); #1;
    reset = 1'b1;
    m_int_en = 1'b1;
    run(32'h0C000010, 0, 0, 0);
    run(32'h8C220004, 0, 0, 0);
    pin_i("lw_cycles", n_cyc, 5);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
